// File: rtl/gray_stream_decoder.sv
// -----------------------------------------------------------------------------
// gray_stream_decoder
//
// Streaming Gray-to-binary decoder with step tracking. Each accepted Gray
// sample is decoded and compared against the previously accepted sample. The
// comparison classifies the step as:
//   - no change (distance 0)
//   - a legal single step (distance 1), which also yields a direction and a
//     wrap flag
//   - an illegal jump (distance >= 2), which raises step_err and bumps a
//     saturating error counter
// The result is registered, so it appears one cycle after the accept, behind a
// valid/ready handshake.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst        : synchronous active-high reset
//   in_valid   : g carries a valid sample
//   in_ready   : block can accept a sample this cycle
//   g          : Gray-coded input sample [WIDTH]
//   out_valid  : result registers hold a valid result
//   out_ready  : downstream takes the result this cycle
//   b          : decoded binary value [WIDTH]
//   dir        : direction of the last legal step (1 = up, 0 = down)
//   step_err   : this result's sample moved by more than one bit
//   wrap       : this result's step crossed between all-ones and zero
//   err_count  : saturating count of step errors [ERR_W]
// -----------------------------------------------------------------------------
module gray_stream_decoder #(
    parameter int WIDTH = 4,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] g,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] b,
    output logic             dir,
    output logic             step_err,
    output logic             wrap,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [1:0] ST_IDLE  = 2'd0;  // no reference sample yet
    localparam logic [1:0] ST_TRACK = 2'd1;  // reference held, steps checked
    localparam logic [1:0] ST_FAULT = 2'd2;  // last step was an illegal jump

    localparam logic [WIDTH-1:0] ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ALL1_W  = {WIDTH{1'b1}};
    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};
    localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};

    logic [1:0]       state_reg;
    logic [1:0]       state_next;
    logic [WIDTH-1:0] ref_reg;
    logic             out_valid_reg;
    logic [WIDTH-1:0] b_reg;
    logic             dir_reg;
    logic             step_err_reg;
    logic             wrap_reg;
    logic [ERR_W-1:0] err_count_reg;

    logic             dir_next;
    logic             step_err_next;
    logic             wrap_next;
    logic             err_inc;

    logic             accept;
    logic [WIDTH-1:0] b_new;
    logic [WIDTH-1:0] b_prev;
    logic [WIDTH-1:0] diff;
    logic             dist_zero;
    logic             dist_one;

    // Binary bit i is the XOR of all Gray bits from i up to the MSB, which is
    // the closed form of b[i] = b[i+1] ^ g[i].
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_decode
            assign b_new[gi]  = ^g[WIDTH-1:gi];
            assign b_prev[gi] = ^ref_reg[WIDTH-1:gi];
        end
    endgenerate

    assign in_ready = !rst && (!out_valid_reg || out_ready);
    assign accept   = in_valid && in_ready;

    // Hamming distance classification without a popcount: exactly one bit set
    // means clearing the lowest set bit leaves zero.
    assign diff      = g ^ ref_reg;
    assign dist_zero = (diff == '0);
    assign dist_one  = !dist_zero && ((diff & (diff - ONE_W)) == '0);

    always_comb begin
        state_next    = state_reg;
        dir_next      = dir_reg;
        step_err_next = 1'b0;
        wrap_next     = 1'b0;
        err_inc       = 1'b0;
        case (state_reg)
            ST_TRACK: begin
                if (dist_zero) begin
                    state_next = ST_TRACK;
                end else if (dist_one) begin
                    state_next = ST_TRACK;
                    dir_next   = (b_new == (b_prev + ONE_W));
                    wrap_next  = ((b_prev == ALL1_W) && (b_new == '0)) ||
                                 ((b_prev == '0) && (b_new == ALL1_W));
                end else begin
                    state_next    = ST_FAULT;
                    step_err_next = 1'b1;
                    err_inc       = 1'b1;
                end
            end
            default: begin
                // IDLE and FAULT both (re)acquire: the sample becomes the new
                // reference without being judged against the old one.
                state_next = ST_TRACK;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            ref_reg       <= '0;
            out_valid_reg <= 1'b0;
            b_reg         <= '0;
            dir_reg       <= 1'b1;
            step_err_reg  <= 1'b0;
            wrap_reg      <= 1'b0;
            err_count_reg <= '0;
        end else if (accept) begin
            state_reg     <= state_next;
            ref_reg       <= g;
            out_valid_reg <= 1'b1;
            b_reg         <= b_new;
            dir_reg       <= dir_next;
            step_err_reg  <= step_err_next;
            wrap_reg      <= wrap_next;
            if (err_inc && (err_count_reg != ERR_MAX)) begin
                err_count_reg <= err_count_reg + ERR_ONE;
            end
        end else if (out_ready) begin
            // Consumed with nothing new behind it.
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid = out_valid_reg;
    assign b         = b_reg;
    assign dir       = dir_reg;
    assign step_err  = step_err_reg;
    assign wrap      = wrap_reg;
    assign err_count = err_count_reg;

endmodule

// File: tb/tb_gray_stream_decoder.sv
// -----------------------------------------------------------------------------
// tb_gray_stream_decoder
//
// Directed bench for gray_stream_decoder. A default-parameter instance covers
// streaming, wrap, error/reacquire, backpressure and mid-stream reset; a
// second instance with ERR_W=2 covers counter saturation. Inputs are driven
// 1 ns after a rising edge and outputs sampled at the same point.
// -----------------------------------------------------------------------------
module tb_gray_stream_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] g = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [3:0] b;
    logic       dir;
    logic       step_err;
    logic       wrap;
    logic [7:0] err_count;

    logic       s_in_valid = 1'b0;
    logic       s_in_ready;
    logic [3:0] s_g = '0;
    logic       s_out_valid;
    logic       s_out_ready = 1'b1;
    logic [3:0] s_b;
    logic       s_dir;
    logic       s_step_err;
    logic       s_wrap;
    logic [1:0] s_err_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    gray_stream_decoder #(.WIDTH(4), .ERR_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .g         (g),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .b         (b),
        .dir       (dir),
        .step_err  (step_err),
        .wrap      (wrap),
        .err_count (err_count)
    );

    gray_stream_decoder #(.WIDTH(4), .ERR_W(2)) dut_sat (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .g         (s_g),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .b         (s_b),
        .dir       (s_dir),
        .step_err  (s_step_err),
        .wrap      (s_wrap),
        .err_count (s_err_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic show(input string tag);
        $display("txn %s g=%b in_ready=%0b out_valid=%0b b=%0d dir=%0b step_err=%0b wrap=%0b err_count=%0d",
                 tag, g, in_ready, out_valid, b, dir, step_err, wrap, err_count);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        in_valid   = 1'b0;
        s_in_valid = 1'b0;
        out_ready  = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in_ready_low got %0b exp 0", in_ready);
        end
        rst = 1'b0;
        #1;
        show("reset");
        n_checks++;
        if ({out_valid, b, dir, step_err, wrap} !== {1'b0, 4'd0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_outputs got v=%0b b=%0d dir=%0b se=%0b wr=%0b exp v=0 b=0 dir=1 se=0 wr=0",
                     out_valid, b, dir, step_err, wrap);
        end
        n_checks++;
        if (err_count !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_err_count got %0d exp 0", err_count);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready_high got %0b exp 1", in_ready);
        end
    endtask

    task automatic test_stream();
        logic [3:0] gv [4];
        gv = '{4'b0000, 4'b0001, 4'b0011, 4'b0010};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            g        = gv[i];
            tick();
            show("stream");
            n_checks++;
            if ({out_valid, b, dir, step_err, wrap} !== {1'b1, 4'(i), 1'b1, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL stream_%0d got v=%0b b=%0d dir=%0b se=%0b wr=%0b exp v=1 b=%0d dir=1 se=0 wr=0",
                         i, out_valid, b, dir, step_err, wrap, i);
            end
        end
        in_valid = 1'b0;
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_drain got out_valid=%0b exp 0", out_valid);
        end
    endtask

    task automatic test_wrap();
        logic [3:0] gv [3];
        logic [3:0] eb [3];
        logic       ew [3];
        logic       ed [3];
        gv = '{4'b1000, 4'b0000, 4'b1000};
        eb = '{4'd15, 4'd0, 4'd15};
        ew = '{1'b0, 1'b1, 1'b1};
        ed = '{1'b1, 1'b1, 1'b0};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            g        = gv[i];
            tick();
            show("wrap");
            n_checks++;
            if ({b, wrap, dir, step_err} !== {eb[i], ew[i], ed[i], 1'b0}) begin
                n_fail++;
                $display("FAIL wrap_%0d got b=%0d wr=%0b dir=%0b se=%0b exp b=%0d wr=%0b dir=%0b se=0",
                         i, b, wrap, dir, step_err, eb[i], ew[i], ed[i]);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_error();
        logic [3:0] gv [4];
        logic [3:0] eb [4];
        logic       ee [4];
        logic [7:0] ec [4];
        gv = '{4'b0000, 4'b0011, 4'b0010, 4'b0110};
        eb = '{4'd0, 4'd2, 4'd3, 4'd4};
        ee = '{1'b0, 1'b1, 1'b0, 1'b0};
        ec = '{8'd0, 8'd1, 8'd1, 8'd1};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            g        = gv[i];
            tick();
            show("error");
            n_checks++;
            if ({b, step_err, err_count, wrap} !== {eb[i], ee[i], ec[i], 1'b0}) begin
                n_fail++;
                $display("FAIL error_%0d got b=%0d se=%0b cnt=%0d wr=%0b exp b=%0d se=%0b cnt=%0d wr=0",
                         i, b, step_err, err_count, wrap, eb[i], ee[i], ec[i]);
            end
        end
        n_checks++;
        if (dir !== 1'b1) begin
            n_fail++;
            $display("FAIL error_dir got %0b exp 1", dir);
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        g         = 4'b0000;
        tick();
        g = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            show("stall");
            n_checks++;
            if ({in_ready, out_valid, b} !== {1'b0, 1'b1, 4'd0}) begin
                n_fail++;
                $display("FAIL stall_%0d got rdy=%0b v=%0b b=%0d exp rdy=0 v=1 b=0",
                         i, in_ready, out_valid, b);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL release_in_ready got %0b exp 1", in_ready);
        end
        tick();
        show("release");
        n_checks++;
        if ({out_valid, b, dir} !== {1'b1, 4'd1, 1'b1}) begin
            n_fail++;
            $display("FAIL release_1 got v=%0b b=%0d dir=%0b exp v=1 b=1 dir=1", out_valid, b, dir);
        end
        g = 4'b0011;
        tick();
        show("release");
        n_checks++;
        if ({out_valid, b} !== {1'b1, 4'd2}) begin
            n_fail++;
            $display("FAIL release_2 got v=%0b b=%0d exp v=1 b=2", out_valid, b);
        end
        in_valid = 1'b0;
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL release_drain got out_valid=%0b exp 0", out_valid);
        end
    endtask

    task automatic test_saturation();
        logic [1:0] ec [5];
        ec = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        do_reset();
        s_out_ready = 1'b1;
        for (int p = 0; p < 5; p++) begin
            s_in_valid = 1'b1;
            s_g        = 4'b0000;
            tick();
            s_g = 4'b0011;
            tick();
            $display("txn sat pair=%0d b=%0d step_err=%0b err_count=%0d", p, s_b, s_step_err, s_err_count);
            n_checks++;
            if ({s_step_err, s_err_count} !== {1'b1, ec[p]}) begin
                n_fail++;
                $display("FAIL sat_%0d got se=%0b cnt=%0d exp se=1 cnt=%0d", p, s_step_err, s_err_count, ec[p]);
            end
        end
        s_in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        in_valid = 1'b1;
        g        = 4'b0000;
        tick();
        g = 4'b0011;
        tick();
        show("pre_rst");
        n_checks++;
        if ({out_valid, err_count} !== {1'b1, 8'd1}) begin
            n_fail++;
            $display("FAIL pre_rst got v=%0b cnt=%0d exp v=1 cnt=1", out_valid, err_count);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst       = 1'b1;
        tick();
        show("mid_rst");
        n_checks++;
        if ({out_valid, err_count, in_ready} !== {1'b0, 8'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL mid_rst got v=%0b cnt=%0d rdy=%0b exp v=0 cnt=0 rdy=0",
                     out_valid, err_count, in_ready);
        end
        rst       = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        g         = 4'b0011;
        tick();
        show("post_rst");
        n_checks++;
        if ({out_valid, b, step_err, err_count} !== {1'b1, 4'd2, 1'b0, 8'd0}) begin
            n_fail++;
            $display("FAIL post_rst got v=%0b b=%0d se=%0b cnt=%0d exp v=1 b=2 se=0 cnt=0",
                     out_valid, b, step_err, err_count);
        end
        in_valid = 1'b0;
        tick();
    endtask

    initial begin
        #1;
        test_reset();
        test_stream();
        test_wrap();
        test_error();
        test_backpressure();
        test_saturation();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
